source_gen2: RTL and testbench

Parametrised successor to the first-generation test-data source for the OFDM transmit chain. It feeds the modulator input with DATA_W-bit symbols over a proper valid/ready stream handshake. It adds selectable PRBS, zero, counter and constant modes, frame delimiting (last), a frame counter and an enable gate. Sits at the head of the TX datapath, ahead of the QAM mapper.

---
 rtl/source_gen2.sv | 122 ++++++++++++
 tb/tb_source_gen2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/source_gen2.sv
// source_gen2: parametrised test-data source for the OFDM TX chain.
// Emits DATA_W-bit beats over a valid/ready stream. The beat can be PRBS,
// zero, a running counter or a constant. Frames are delimited with last,
// and completed frames are counted. The LFSRs and the beat counter advance
// on every loaded beat whatever the mode, so the sequences stay beat-aligned.
module source_gen2 #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [15:0] SEED16    = 16'hACE1,
  parameter logic [31:0] SEED32    = 32'hDEADBEEF,
  parameter logic [7:0]  CONST_VAL = 8'hAA
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned IDX_W    = 16;
  localparam int unsigned FCNT_W   = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] CONST_W = DATA_W'(CONST_VAL);

  localparam logic [1:0] MODE_PRBS  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_CONST = 2'b11;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [15:0]       lfsr16_q, lfsr16_d;
  logic [31:0]       lfsr32_q, lfsr32_d;

  logic              xfer;
  logic              load;
  logic              at_last;
  logic [DATA_W-1:0] word;

  // Handshake qualifiers and the word selected by the current mode
  always_comb begin
    xfer    = valid_q & ready;
    load    = enable & (~valid_q | ready);
    at_last = (beat_idx_q == LAST_IDX);
    word    = '0;
    unique case (mode)
      MODE_PRBS:  word = lfsr16_q[DATA_W-1:0] ^ lfsr32_q[DATA_W+7:8];
      MODE_ZERO:  word = '0;
      MODE_COUNT: word = cnt_q;
      MODE_CONST: word = CONST_W;
      default:    word = '0;
    endcase
  end

  // Next-state: load a new beat, retire an accepted one, or hold under stall
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    beat_idx_d  = beat_idx_q;
    cnt_d       = cnt_q;
    lfsr16_d    = lfsr16_q;
    lfsr32_d    = lfsr32_q;

    if (xfer && last_q) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    if (load) begin
      valid_d    = 1'b1;
      data_d     = word;
      last_d     = at_last;
      beat_idx_d = at_last ? '0 : beat_idx_q + IDX_W'(1);
      cnt_d      = cnt_q + DATA_W'(1);
      lfsr16_d   = {lfsr16_q[14:0],
                    lfsr16_q[15] ^ lfsr16_q[13] ^ lfsr16_q[12] ^ lfsr16_q[10]};
      lfsr32_d   = {lfsr32_q[30:0],
                    lfsr32_q[31] ^ lfsr32_q[21] ^ lfsr32_q[1] ^ lfsr32_q[0]};
    end else if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
      beat_idx_q  <= '0;
      cnt_q       <= '0;
      lfsr16_q    <= SEED16;
      lfsr32_q    <= SEED32;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
      beat_idx_q  <= beat_idx_d;
      cnt_q       <= cnt_d;
      lfsr16_q    <= lfsr16_d;
      lfsr32_q    <= lfsr32_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_source_gen2.sv
// Bench for source_gen2: directed opening checks, then randomized
// enable/ready/mode/reset stimulus compared against a beat-number model.
module tb_source_gen2;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned TAB       = 8192;

  logic              aclk;
  logic              reset;
  logic              enable;
  logic [1:0]        mode;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic [15:0]       frame_cnt;

  source_gen2 #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .aclk(aclk), .reset(reset), .enable(enable), .mode(mode), .ready(ready),
    .data(data), .valid(valid), .last(last), .frame_cnt(frame_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // LFSR states indexed by number of beats loaded since reset
  logic [15:0] l16_tab [TAB];
  logic [31:0] l32_tab [TAB];

  // Model: k = beats loaded since reset, plus the visible output state
  int unsigned k;
  logic        m_valid;
  logic        m_last;
  logic [7:0]  m_data;
  logic [15:0] m_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_word(input int unsigned n, input logic [1:0] m);
    logic [15:0] a;
    logic [31:0] b;
    a = l16_tab[n % TAB];
    b = l32_tab[n % TAB];
    case (m)
      2'b00:   return a[7:0] ^ b[15:8];
      2'b01:   return 8'h00;
      2'b10:   return 8'(n % 256);
      default: return 8'hAA;
    endcase
  endfunction

  task automatic model_reset();
    k        = 0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = 8'h00;
    m_frames = 16'h0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    logic xf, ld;
    @(posedge aclk);
    if (!reset) begin
      xf = m_valid & ready;
      ld = enable & (~m_valid | ready);
      if (xf && m_last) m_frames = m_frames + 16'd1;
      if (ld) begin
        m_data  = exp_word(k, mode);
        m_last  = ((k % FRAME_LEN) == FRAME_LEN - 1);
        m_valid = 1'b1;
        k++;
      end else if (xf) begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
    end
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    check("data", 32'(data), 32'(m_data));
    check("last", 32'(last), 32'(m_last));
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
  endtask

  initial begin
    logic [15:0] s16;
    logic [31:0] s32;
    s16 = 16'hACE1;
    s32 = 32'hDEADBEEF;
    for (int i = 0; i < int'(TAB); i++) begin
      l16_tab[i] = s16;
      l32_tab[i] = s32;
      s16 = {s16[14:0], s16[15] ^ s16[13] ^ s16[12] ^ s16[10]};
      s32 = {s32[30:0], s32[31] ^ s32[21] ^ s32[1] ^ s32[0]};
    end

    reset  = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge aclk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Directed opening: PRBS words 0x5F, 0xBE on consecutive cycles
    enable = 1'b1;
    ready  = 1'b1;
    reset  = 1'b0;
    step();
    check("first_word", 32'(data), 32'h5F);
    check("first_valid", 32'(valid), 32'd1);
    step();
    check("second_word", 32'(data), 32'hBE);

    // Complete the first frames at full rate so frame_cnt reaches 3
    for (int i = 0; i < 22; i++) step();
    check("frames_after_24", 32'(frame_cnt), 32'd2);
    step();
    check("frames_after_25", 32'(frame_cnt), 32'd3);

    // Stall for 5 cycles on a live beat, output held by the model
    @(negedge aclk);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    @(negedge aclk);
    ready = 1'b1;
    step();

    // Enable drop under backpressure: beat held, then valid falls
    @(negedge aclk);
    enable = 1'b0;
    ready  = 1'b0;
    step();
    step();
    @(negedge aclk);
    ready = 1'b1;
    step();
    step();
    check("drained_valid", 32'(valid), 32'd0);
    @(negedge aclk);
    enable = 1'b1;
    step();

    // Randomized phase with occasional mid-frame resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_data", 32'(data), 32'd0);
        check("async_rst_last", 32'(last), 32'd0);
        check("async_rst_frames", 32'(frame_cnt), 32'd0);
        model_reset();
        step();
        @(negedge aclk);
        reset  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        mode   = 2'b00;
        step();
        check("post_rst_word", 32'(data), 32'h5F);
        check("post_rst_last", 32'(last), 32'd0);
        check("post_rst_frames", 32'(frame_cnt), 32'd0);
      end else begin
        enable = ($urandom_range(0, 99) < 85);
        ready  = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
